plic_lite: RTL and testbench
============================

# plic_lite

Small external-interrupt controller sitting between peripheral interrupt lines and the CPU's CSR/privilege unit. It gathers up to 31 sources and latches them as level- or edge-triggered pending bits, masks them with an enable register, and drives the single `m_eip` level into the privilege unit. It consumes `m_eip_reply` and gives the M-mode handler a claim/complete register pair over the MMIO bus.

## Interface
- `NSRC`, 8: number of interrupt sources, 1..31; source IDs are 1..NSRC, ID 0 means "none".
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `a` in 2: word address (0 PENDING, 1 ENABLE, 2 CLAIM/COMPLETE, 3 EDGE).
- `d` in 32: write data.
- `we` in 1: write strobe, one cycle per access.
- `rd` in 1: read strobe, one cycle per access; only CLAIM has a read side effect.
- `spo` out 32: combinational read data for `a`; unused high bits read 0.
- `irq_in` in NSRC: raw peripheral lines, possibly asynchronous.
- `m_eip` out 1: registered external-interrupt level to the privilege unit.
- `m_eip_reply` in 1: single-cycle pulse from the privilege unit when it issues the interrupt to the CPU.

## Operation
- **Synchronizer:** 2-flop synchronizer per `irq_in` bit, giving `s[i]`. For edge mode, also keep the previous value `s_d[i]`.
- **Gateway i (bit i-1):**
  - Level mode (EDGE[i]=0): pending sets when `s` is high and source i is not in service.
  - Edge mode: pending sets on `s & ~s_d`, including while i is in service.
- **PENDING:** read-only; writes are ignored.
- **ENABLE, EDGE:** read/write, reset 0.
- **Winner:** the lowest index among `PENDING & ENABLE`, as ID = index+1, or 0 if none.
- **Claim:** `rd` with a=2 returns the winner ID on `spo`. At the clock edge:
  - if the ID is non-zero, clear that pending bit, set `in_service_id` to the ID, and go to SERVICE;
  - if the ID is 0, nothing changes.
- **Complete:** `we` with a=2 and `d[4:0]` equal to `in_service_id` clears in-service and goes to IDLE. Any other ID is ignored.
- **FSM** (registered; `m_eip` = state is ASSERT or TAKEN):
  - IDLE: go to ASSERT when the winner is non-zero.
  - ASSERT: go to TAKEN on `m_eip_reply`; go to IDLE if the winner becomes 0 (source disabled); go to SERVICE on a claim.
  - TAKEN: go to SERVICE on a claim; go to IDLE if the winner becomes 0.
  - SERVICE: `m_eip` is low; go to IDLE on a matching complete.
- Only one source is in service at a time; there is no nesting.

## Timing
- **Reset values:** `m_eip`=0, state IDLE, PENDING/ENABLE/EDGE/in-service all 0, sync flops 0. Reset mid-service drops everything and never leaves a stale claim.
- **Latency:** `irq_in` rises before edge k → `s` high after k+1 → pending set at k+2 → `m_eip` high at k+3.
- **Claim to `m_eip`:** `m_eip` falls on the edge that accepts the claim.
- **Re-raise after complete:** after a complete at edge c, another winner raises `m_eip` at c+1 (IDLE at c, ASSERT at c+1).
- **Simultaneous events:**
  - Claim of i and a new edge on i in the same cycle: pending stays set (set wins).
  - Claim and `m_eip_reply` in the same cycle: claim wins → SERVICE.
  - Disabling the winner in ASSERT: `m_eip` falls one cycle later.
  - `we` and `rd` to the same address in one cycle: the write takes effect; the read returns the pre-write value.
- **`m_eip_reply` outside ASSERT:** ignored.

## Structure
- **Package `plic_lite_pkg`:**
  - register offsets `PLIC_PENDING`, `PLIC_ENABLE`, `PLIC_CLAIM`, `PLIC_EDGE`;
  - the 2-bit state encoding IDLE/ASSERT/TAKEN/SERVICE;
  - `PLIC_MAX_SRC`=31.
- **Sub-module `irq_gateway`:** one per source (generate loop). It holds the synchronizer, edge detect and pending flop, with inputs `edge_mode`, `in_service`, `clr` and output `pending`.
- **Top level:** priority encoder, FSM, register file and read mux.

## Test plan
- ENABLE=0x04, level source 3 raised at edge 0 → PENDING=0x04 at edge 2, `m_eip`=1 at edge 3; claim read returns 3, `m_eip`=0 next edge; complete 3 with line still high → re-pended, `m_eip` high again.
- Sources 2 and 5 both pending and enabled → claim returns 2; after complete 2, the next claim returns 5.
- Edge source 1 pulses twice while in service → PENDING bit 0 still set after complete; a second claim returns 1; a third returns 0.
- In ASSERT, write ENABLE=0 → `m_eip` falls next cycle, state IDLE, PENDING retained.
- Claim read with nothing pending → 0, no state change; complete with ID 7 while 3 is in service → ignored, SERVICE held.
- `rst` asserted in SERVICE → all registers 0 and `m_eip`=0 on the next edge; `m_eip_reply` pulse in IDLE → no effect.

Source files
------------

// File: rtl/plic_lite_pkg.sv
// Shared definitions for the plic_lite interrupt controller: register map,
// FSM state encoding and source-count limit.
package plic_lite_pkg;

  localparam int PLIC_MAX_SRC = 31;

  localparam logic [1:0] PLIC_PENDING = 2'd0;
  localparam logic [1:0] PLIC_ENABLE  = 2'd1;
  localparam logic [1:0] PLIC_CLAIM   = 2'd2;
  localparam logic [1:0] PLIC_EDGE    = 2'd3;

  // Bit 0 set exactly in the states that drive m_eip, so the output is a flop bit.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ASSERT  = 2'b01,
    ST_TAKEN   = 2'b11,
    ST_SERVICE = 2'b10
  } plic_state_t;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop synchronizer, edge detect and pending latch.
module irq_gateway (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic in_service,
  input  logic clr,
  output logic pending
);

  logic s1, s, s_d, set;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= irq;
      s   <= s1;
      s_d <= s;
    end
  end

  assign set = edge_mode ? (s & ~s_d) : (s & ~in_service);

  // A new set in the same cycle as a claim keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else     pending <= set | (pending & ~clr);
  end

endmodule

// File: rtl/plic_lite.sv
// Lightweight external-interrupt controller: gateways, lowest-ID priority,
// claim/complete register pair and the m_eip handshake FSM.
//
// state   | meaning
// IDLE    | no enabled pending source seen, m_eip low
// ASSERT  | winner present, m_eip high, privilege unit not yet replied
// TAKEN   | privilege unit issued the interrupt, waiting for the claim read
// SERVICE | one source claimed, m_eip low until its matching complete
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            rd,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] irq_in,
  output logic            m_eip,
  input  logic            m_eip_reply
);

  logic [NSRC-1:0] pending, enable, edge_sel, active, svc_vec, clr_vec;
  logic [4:0]      winner, claim_id, svc_id;
  logic            claim, complete;
  plic_state_t     state, state_nx;

  assign active = pending & enable;

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (active[i]) winner = 5'(i + 1);
  end

  // No nesting: while a source is in service the claim register reads 0.
  assign claim_id = (state == ST_SERVICE) ? 5'd0 : winner;
  assign claim    = rd && (a == PLIC_CLAIM) && (claim_id != 5'd0);
  assign complete = we && (a == PLIC_CLAIM) && (svc_id != 5'd0) && (d[4:0] == svc_id);

  // The claiming source counts as in service already, so a level line still
  // high at the claim edge does not immediately re-pend.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign clr_vec[g] = claim && (claim_id == 5'(g + 1));
    assign svc_vec[g] = (svc_id == 5'(g + 1)) || clr_vec[g];

    irq_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq_in[g]),
      .edge_mode  (edge_sel[g]),
      .in_service (svc_vec[g]),
      .clr        (clr_vec[g]),
      .pending    (pending[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable   <= '0;
      edge_sel <= '0;
      svc_id   <= '0;
    end else begin
      if (we && a == PLIC_ENABLE) enable   <= d[NSRC-1:0];
      if (we && a == PLIC_EDGE)   edge_sel <= d[NSRC-1:0];
      if (claim)                  svc_id   <= claim_id;
      else if (complete)          svc_id   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (claim)                state_nx = ST_SERVICE;
        else if (winner != 5'd0)  state_nx = ST_ASSERT;
      ST_ASSERT:
        if (claim)                state_nx = ST_SERVICE;
        else if (winner == 5'd0)  state_nx = ST_IDLE;
        else if (m_eip_reply)     state_nx = ST_TAKEN;
      ST_TAKEN:
        if (claim)                state_nx = ST_SERVICE;
        else if (winner == 5'd0)  state_nx = ST_IDLE;
      ST_SERVICE:
        if (complete)             state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    m_eip = (state == ST_ASSERT) || (state == ST_TAKEN);
  end

  always_comb begin
    spo = '0;
    case (a)
      PLIC_PENDING: spo = 32'(pending);
      PLIC_ENABLE:  spo = 32'(enable);
      PLIC_CLAIM:   spo = 32'(claim_id);
      PLIC_EDGE:    spo = 32'(edge_sel);
      default:      spo = '0;
    endcase
  end

endmodule

// File: tb/tb_plic_lite.sv
// Directed scenario checks plus a randomized run against a behavioural model
// of the controller (pending bits, in-service ID and expected m_eip level).
module tb_plic_lite;
  import plic_lite_pkg::*;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      a;
  logic [31:0]     d;
  logic            we, rd;
  logic [31:0]     spo;
  logic [NSRC-1:0] irq_in;
  logic            m_eip, m_eip_reply;

  int n_vec = 0;
  int n_err = 0;

  plic_lite #(.NSRC(NSRC)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .d           (d),
    .we          (we),
    .rd          (rd),
    .spo         (spo),
    .irq_in      (irq_in),
    .m_eip       (m_eip),
    .m_eip_reply (m_eip_reply)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NSRC-1:0] r_s1, r_s, r_sd, r_pend, r_en, r_edge;
  int              r_svc;
  bit              r_eip;

  function automatic int winner_of(logic [NSRC-1:0] p, logic [NSRC-1:0] e);
    for (int i = 0; i < NSRC; i++)
      if (p[i] && e[i]) return i + 1;
    return 0;
  endfunction

  function automatic int claim_val();
    return (r_svc != 0) ? 0 : winner_of(r_pend, r_en);
  endfunction

  function automatic logic [31:0] exp_spo(logic [1:0] addr);
    case (addr)
      2'd0:    return 32'(r_pend);
      2'd1:    return 32'(r_en);
      2'd2:    return 32'(claim_val());
      default: return 32'(r_edge);
    endcase
  endfunction

  always @(posedge clk) begin
    int w, cid;
    bit claim_now, cl, insvc, st;
    logic [NSRC-1:0] np;
    w = winner_of(r_pend, r_en);
    cid = claim_val();
    claim_now = rd && (a == 2'd2) && (cid != 0);
    if (rst) begin
      r_s1 = '0; r_s = '0; r_sd = '0; r_pend = '0; r_en = '0; r_edge = '0;
      r_svc = 0; r_eip = 0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        cl = claim_now && (cid == i + 1);
        insvc = (r_svc == i + 1) || cl;
        st = r_edge[i] ? (r_s[i] && !r_sd[i]) : (r_s[i] && !insvc);
        np[i] = st || (r_pend[i] && !cl);
      end
      r_eip = (r_svc == 0) && !claim_now && (w != 0);
      if (we && a == 2'd1) r_en = d[NSRC-1:0];
      if (we && a == 2'd3) r_edge = d[NSRC-1:0];
      if (we && a == 2'd2 && r_svc != 0 && int'(d[4:0]) == r_svc) r_svc = 0;
      if (claim_now) r_svc = cid;
      r_pend = np;
      r_sd = r_s;
      r_s = r_s1;
      r_s1 = irq_in;
    end
  end

  // One bus cycle: drive at the falling edge, settle, return for sampling.
  task automatic apply(input logic [1:0] aa, input logic [31:0] dd, input logic w, input logic r);
    @(negedge clk);
    a = aa; d = dd; we = w; rd = r;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_in = '0; m_eip_reply = 1'b0;
    apply(2'd0, 32'd0, 1'b0, 1'b0);
    apply(2'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply(2'(k), 32'd0, 1'b0, 1'b0);
      n_vec++;
      if (spo !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d spo=%h want 0", k, spo); end
    end
    n_vec++;
    if (m_eip !== 1'b0) begin n_err++; $display("FAIL reset_eip m_eip=%b want 0", m_eip); end
    rst = 1'b0;
  endtask

  task automatic test_level_claim();
    do_reset();
    apply(PLIC_ENABLE, 32'h04, 1'b1, 1'b0);
    irq_in[2] = 1'b1;
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (spo !== 32'd0) begin n_err++; $display("FAIL lvl_pend_e0 spo=%h want 0", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (spo !== 32'h04 || m_eip !== 1'b0) begin n_err++; $display("FAIL lvl_pend_e2 spo=%h eip=%b want 04/0", spo, m_eip); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b1) begin n_err++; $display("FAIL lvl_eip_e3 m_eip=%b want 1", m_eip); end
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd3) begin n_err++; $display("FAIL lvl_claim spo=%0d want 3", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0 || spo !== 32'd0) begin n_err++; $display("FAIL lvl_after_claim eip=%b pend=%h want 0/0", m_eip, spo); end
    apply(PLIC_CLAIM, 32'd3, 1'b1, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (spo !== 32'h04) begin n_err++; $display("FAIL lvl_repend spo=%h want 04", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b1) begin n_err++; $display("FAIL lvl_reraise m_eip=%b want 1", m_eip); end
  endtask

  task automatic test_priority();
    do_reset();
    apply(PLIC_ENABLE, 32'h12, 1'b1, 1'b0);
    irq_in = 8'h12;
    repeat (4) apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd2) begin n_err++; $display("FAIL prio_first spo=%0d want 2", spo); end
    irq_in[1] = 1'b0;
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd2, 1'b1, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd5) begin n_err++; $display("FAIL prio_second spo=%0d want 5", spo); end
  endtask

  task automatic test_edge_in_service();
    do_reset();
    apply(PLIC_EDGE, 32'h01, 1'b1, 1'b0);
    apply(PLIC_ENABLE, 32'h01, 1'b1, 1'b0);
    irq_in[0] = 1'b1;
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    irq_in[0] = 1'b0;
    repeat (4) apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd1) begin n_err++; $display("FAIL edge_claim1 spo=%0d want 1", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      irq_in[0] = 1'b1;
      apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
      irq_in[0] = 1'b0;
      apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
      apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    end
    repeat (2) apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (spo !== 32'h01 || m_eip !== 1'b0) begin n_err++; $display("FAIL edge_svc_pend spo=%h eip=%b want 01/0", spo, m_eip); end
    apply(PLIC_CLAIM, 32'd1, 1'b1, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (spo !== 32'h01) begin n_err++; $display("FAIL edge_after_cmp spo=%h want 01", spo); end
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd1) begin n_err++; $display("FAIL edge_claim2 spo=%0d want 1", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd1, 1'b1, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd0) begin n_err++; $display("FAIL edge_claim3 spo=%0d want 0", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_disable();
    do_reset();
    apply(PLIC_ENABLE, 32'h04, 1'b1, 1'b0);
    irq_in[2] = 1'b1;
    repeat (4) apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b1) begin n_err++; $display("FAIL dis_assert m_eip=%b want 1", m_eip); end
    apply(PLIC_ENABLE, 32'h00, 1'b1, 1'b1);
    n_vec++;
    if (spo !== 32'h04) begin n_err++; $display("FAIL dis_rdwr spo=%h want 04 (pre-write)", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b1) begin n_err++; $display("FAIL dis_eip_e m_eip=%b want 1", m_eip); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0 || spo !== 32'h04) begin n_err++; $display("FAIL dis_eip_e1 eip=%b pend=%h want 0/04", m_eip, spo); end
  endtask

  task automatic test_claim_none_bad_complete();
    do_reset();
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd0) begin n_err++; $display("FAIL none_claim spo=%0d want 0", spo); end
    apply(PLIC_ENABLE, 32'h0c, 1'b1, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0) begin n_err++; $display("FAIL none_eip m_eip=%b want 0", m_eip); end
    irq_in = 8'h0c;
    repeat (4) apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    n_vec++;
    if (spo !== 32'd3) begin n_err++; $display("FAIL bad_claim3 spo=%0d want 3", spo); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd7, 1'b1, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0 || spo !== 32'd0) begin n_err++; $display("FAIL bad_cmp_held eip=%b claim=%0d want 0/0", m_eip, spo); end
    apply(PLIC_CLAIM, 32'd3, 1'b1, 1'b0);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0) begin n_err++; $display("FAIL cmp_idle m_eip=%b want 0", m_eip); end
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b1) begin n_err++; $display("FAIL cmp_reraise m_eip=%b want 1", m_eip); end
  endtask

  task automatic test_reset_in_service();
    do_reset();
    apply(PLIC_ENABLE, 32'h04, 1'b1, 1'b0);
    irq_in[2] = 1'b1;
    repeat (4) apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b1);
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    irq_in = '0;
    rst = 1'b1;
    apply(PLIC_PENDING, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0 || spo !== 32'd0) begin n_err++; $display("FAIL rst_svc eip=%b pend=%h want 0/0", m_eip, spo); end
    rst = 1'b0;
    apply(PLIC_ENABLE, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (spo !== 32'd0) begin n_err++; $display("FAIL rst_svc_en spo=%h want 0", spo); end
    m_eip_reply = 1'b1;
    apply(PLIC_CLAIM, 32'd3, 1'b1, 1'b0);
    m_eip_reply = 1'b0;
    apply(PLIC_CLAIM, 32'd0, 1'b0, 1'b0);
    n_vec++;
    if (m_eip !== 1'b0 || spo !== 32'd0) begin n_err++; $display("FAIL reply_idle eip=%b claim=%0d want 0/0", m_eip, spo); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [1:0]  aa;
      logic [31:0] dd;
      logic        w, r;
      if ($urandom_range(0, 3) == 0) irq_in = NSRC'($urandom);
      m_eip_reply = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      aa = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 2) == 0);
      dd = $urandom;
      if (aa == PLIC_CLAIM && $urandom_range(0, 1) == 1) dd = 32'(r_svc);
      apply(aa, dd, w, r);
      n_vec++;
      if (m_eip !== r_eip) begin n_err++; $display("FAIL rnd_eip cyc=%0d m_eip=%b want %b", k, m_eip, r_eip); end
      n_vec++;
      if (spo !== exp_spo(aa)) begin n_err++; $display("FAIL rnd_spo cyc=%0d a=%0d spo=%h want %h", k, aa, spo, exp_spo(aa)); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0;
    irq_in = '0; m_eip_reply = 1'b0;
    test_reset();
    test_level_claim();
    test_priority();
    test_edge_in_service();
    test_disable();
    test_claim_none_bad_complete();
    test_reset_in_service();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
